// File: rtl/systolic_drain.sv
// Deskews the skewed row-end results of the PE array into aligned vectors and
// buffers them in a small FIFO behind a ready/valid interface.
module systolic_drain #(
  parameter int ARRAY_M      = 32,
  parameter int PE_OUT_WIDTH = 21,
  parameter int PIPE_LAT     = 2,
  parameter int FIFO_DEPTH   = 4,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic [CNT_WIDTH-1:0]            num_vec,
  input  logic [ARRAY_M*PE_OUT_WIDTH-1:0] systolic_out,
  output logic [ARRAY_M*PE_OUT_WIDTH-1:0] out_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic                            out_last,
  output logic                            busy,
  output logic                            done,
  output logic                            overflow
);

  localparam int VW = ARRAY_M * PE_OUT_WIDTH;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int P0 = PIPE_LAT + ARRAY_M - 1;
  localparam logic [CNT_WIDTH-1:0] WAIT_END = CNT_WIDTH'(P0 - 1);
  localparam logic [PW:0] FULL_CNT = (PW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT    = 2'd1,
    S_CAPTURE = 2'd2,
    S_DRAIN   = 2'd3
  } state_t;

  logic [VW-1:0] aligned_s;

  // Row m is delayed by ARRAY_M-1-m cycles so all rows line up with the last row.
  for (genvar m = 0; m < ARRAY_M; m++) begin : g_row
    localparam int DLY = ARRAY_M - 1 - m;
    if (DLY == 0) begin : g_pass
      assign aligned_s[m*PE_OUT_WIDTH +: PE_OUT_WIDTH] = systolic_out[m*PE_OUT_WIDTH +: PE_OUT_WIDTH];
    end else begin : g_dly
      logic [PE_OUT_WIDTH-1:0] sr_d [DLY];
      logic [PE_OUT_WIDTH-1:0] sr_q [DLY];

      always_comb begin
        sr_d[0] = systolic_out[m*PE_OUT_WIDTH +: PE_OUT_WIDTH];
        for (int i = 1; i < DLY; i++) begin
          sr_d[i] = sr_q[i-1];
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < DLY; i++) begin
            sr_q[i] <= '0;
          end
        end else begin
          sr_q <= sr_d;
        end
      end

      assign aligned_s[m*PE_OUT_WIDTH +: PE_OUT_WIDTH] = sr_q[DLY-1];
    end
  end

  state_t                 state_q, state_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0]   kcnt_q, kcnt_d;
  logic [CNT_WIDTH-1:0]   klast_q, klast_d;
  logic                   done_q, done_d;
  logic                   busy_q;
  logic                   ovf_q, ovf_d;
  logic                   valid_q;
  logic [VW-1:0]          mem_q [FIFO_DEPTH];
  logic [VW-1:0]          mem_d [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0]  last_q, last_d;
  logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
  logic [PW:0]            count_q, count_d;
  logic                   push_s, push_last_s, pop_s, full_s, wr_s, drop_s;

  assign push_s      = (state_q == S_CAPTURE);
  assign push_last_s = (kcnt_q == klast_q);

  // FIFO bookkeeping; a push into a full FIFO only survives if a pop frees a slot.
  always_comb begin
    mem_d    = mem_q;
    last_d   = last_q;
    full_s   = (count_q == FULL_CNT);
    pop_s    = valid_q & out_ready;
    wr_s     = push_s & (~full_s | pop_s);
    drop_s   = push_s & full_s & ~pop_s;
    ovf_d    = ovf_q | drop_s;
    if (wr_s) begin
      mem_d[wr_ptr_q]  = aligned_s;
      last_d[wr_ptr_q] = push_last_s;
    end else begin
      last_d = last_q;
    end
    wr_ptr_d = wr_ptr_q + PW'(wr_s);
    rd_ptr_d = rd_ptr_q + PW'(pop_s);
    count_d  = count_q + (PW + 1)'(wr_s) - (PW + 1)'(pop_s);
  end

  // Tile sequencing: wait for vector 0 to align, capture K vectors, then drain.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    kcnt_d  = kcnt_q;
    klast_d = klast_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start && (num_vec == '0)) begin
          done_d = 1'b1;
        end else if (start) begin
          klast_d = num_vec - CNT_WIDTH'(1);
          kcnt_d  = '0;
          cnt_d   = CNT_WIDTH'(1);
          state_d = (P0 == 1) ? S_CAPTURE : S_WAIT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (cnt_q == WAIT_END) begin
          state_d = S_CAPTURE;
        end else begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
        end
      end
      S_CAPTURE: begin
        if (push_last_s) begin
          state_d = S_DRAIN;
        end else begin
          kcnt_d = kcnt_q + CNT_WIDTH'(1);
        end
      end
      S_DRAIN: begin
        if (count_d == '0) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = S_DRAIN;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, FIFO storage and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      kcnt_q   <= '0;
      klast_q  <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      ovf_q    <= 1'b0;
      valid_q  <= 1'b0;
      last_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      kcnt_q   <= kcnt_d;
      klast_q  <= klast_d;
      done_q   <= done_d;
      busy_q   <= (state_d != S_IDLE);
      ovf_q    <= ovf_d;
      valid_q  <= (count_d != '0);
      last_q   <= last_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      mem_q    <= mem_d;
    end
  end

  assign out_data  = mem_q[rd_ptr_q];
  assign out_last  = last_q[rd_ptr_q];
  assign out_valid = valid_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_systolic_drain.sv
// Directed and randomized checks of systolic_drain against a transaction-level
// model: a queue of expected vectors, a tile cycle counter and a sticky drop flag.
module tb_systolic_drain;
  localparam int M  = 4;
  localparam int W  = 21;
  localparam int PL = 3;
  localparam int D  = 4;
  localparam int CW = 16;
  localparam int P0 = PL + M - 1;

  logic clk = 1'b0;
  logic rst, start, out_ready, out_valid, out_last, busy, done, overflow;
  logic [CW-1:0] num_vec;
  logic [M*W-1:0] systolic_out, out_data;

  always #5 clk = ~clk;

  systolic_drain #(.ARRAY_M(M), .PE_OUT_WIDTH(W), .PIPE_LAT(PL), .FIFO_DEPTH(D), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .num_vec(num_vec), .systolic_out(systolic_out),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .busy(busy), .done(done), .overflow(overflow));

  int checks = 0;
  int errors = 0;

  // reference model
  logic [M*W:0] mq[$];
  bit m_ovf = 1'b0, m_active = 1'b0, m_done = 1'b0;
  int m_t = 0, m_k = 0;
  logic [W-1:0] tdata [64][M];

  int cyc = 0, start_cyc = 0;
  int ready_mode = 0, ready_after = 0;
  int done_rel, ovf_rel, valid_rel, obs_pops, obs_lasts, obs_dones;

  task automatic chk(input string tag, input logic [M*W:0] obs, input logic [M*W:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic fill_rand();
    for (int k = 0; k < 64; k++)
      for (int m = 0; m < M; m++) tdata[k][m] = W'($urandom);
  endtask

  // one clock cycle: drive, advance the model, clock, compare
  task automatic tick();
    logic [M*W:0] ent;
    int k;
    for (int m = 0; m < M; m++) begin
      k = m_t - PL - m;
      if (m_active && k >= 0 && k < m_k) systolic_out[m*W +: W] = tdata[k][m];
      else systolic_out[m*W +: W] = W'($urandom);
    end
    case (ready_mode)
      0: out_ready = 1'b1;
      1: out_ready = 1'($urandom_range(0, 1));
      default: out_ready = ((cyc - start_cyc) >= ready_after);
    endcase
    if (out_valid && out_ready && !rst) begin
      obs_pops++;
      if (out_last) obs_lasts++;
    end
    m_done = 1'b0;
    if (rst) begin
      mq.delete();
      m_ovf = 1'b0;
      m_active = 1'b0;
    end else begin
      if (mq.size() > 0 && out_ready) ent = mq.pop_front();
      if (m_active && m_t >= P0 && m_t < P0 + m_k) begin
        if (mq.size() == D) m_ovf = 1'b1;
        else begin
          for (int m = 0; m < M; m++) ent[m*W +: W] = tdata[m_t-P0][m];
          ent[M*W] = ((m_t - P0) == m_k - 1);
          mq.push_back(ent);
        end
      end
      if (m_active) begin
        m_t++;
        if (m_t >= P0 + m_k && mq.size() == 0) begin
          m_active = 1'b0;
          m_done = 1'b1;
        end
      end else if (start) begin
        start_cyc = cyc;
        if (num_vec == 0) m_done = 1'b1;
        else begin
          m_active = 1'b1;
          m_t = 1;
          m_k = int'(num_vec);
        end
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    chk("out_valid", out_valid, mq.size() != 0);
    if (mq.size() != 0) chk("head", {out_last, out_data}, mq[0]);
    chk("busy", busy, m_active);
    chk("done", done, m_done);
    chk("overflow", overflow, m_ovf);
    if (done) obs_dones++;
    if (done && done_rel < 0) done_rel = cyc - start_cyc;
    if (overflow && ovf_rel < 0) ovf_rel = cyc - start_cyc;
    if (out_valid && valid_rel < 0) valid_rel = cyc - start_cyc;
  endtask

  task automatic clear_obs();
    done_rel = -1; ovf_rel = -1; valid_rel = -1;
    obs_pops = 0; obs_lasts = 0; obs_dones = 0;
  endtask

  task automatic run_tile(input int k, input int rmode, input int rafter);
    num_vec = CW'(k);
    ready_mode = rmode;
    ready_after = rafter;
    clear_obs();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 400 && done_rel < 0; i++) tick();
    chk("tile_done_seen", done_rel >= 0, 1'b1);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; num_vec = '0; out_ready = 1'b1; systolic_out = '0;
    clear_obs();
    tick(); tick();
    chk("reset_data", out_data, '0);
    chk("reset_last", out_last, 1'b0);
    rst = 1'b0;
    tick();

    // K=1, rows carry 100+m
    for (int m = 0; m < M; m++) tdata[0][m] = W'(100 + m);
    run_tile(1, 0, 0);
    chk("k1_valid_cycle", valid_rel, 7);
    chk("k1_done_cycle", done_rel, 8);
    chk("k1_lasts", obs_lasts, 1);

    // K=3, rows carry 10*k+m
    for (int k = 0; k < 3; k++)
      for (int m = 0; m < M; m++) tdata[k][m] = W'(10 * k + m);
    tick();
    run_tile(3, 0, 0);
    chk("k3_valid_cycle", valid_rel, 7);
    chk("k3_done_cycle", done_rel, 10);
    chk("k3_pops", obs_pops, 3);

    // K=6 with consumer stalled until cycle 20: two vectors dropped
    fill_rand();
    tick();
    run_tile(6, 2, 20);
    chk("k6_ovf_cycle", ovf_rel, 11);
    chk("k6_pops", obs_pops, 4);
    chk("k6_lasts", obs_lasts, 0);
    tick(); tick();
    chk("k6_ovf_sticky", overflow, 1'b1);

    rst = 1'b1; tick(); rst = 1'b0; tick();

    // K=0 start
    run_tile(0, 0, 0);
    chk("k0_done_cycle", done_rel, 1);
    tick(); tick();
    chk("k0_valid_seen", valid_rel, -1);
    chk("k0_dones", obs_dones, 1);

    // reset in cycle 8 of a K=5 tile
    fill_rand();
    num_vec = CW'(5);
    ready_mode = 0;
    clear_obs();
    start = 1'b1; tick(); start = 1'b0;
    while (cyc - start_cyc < 8) tick();
    rst = 1'b1; tick(); rst = 1'b0;
    chk("midrst_data", out_data, '0);
    chk("midrst_flags", {out_valid, out_last, busy, done, overflow}, 5'b00000);
    tick();
    fill_rand();
    run_tile(4, 0, 0);
    chk("after_rst_pops", obs_pops, 4);

    // second start while busy is ignored
    fill_rand();
    tick();
    num_vec = CW'(2);
    ready_mode = 0;
    clear_obs();
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick(); tick();
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 200 && done_rel < 0; i++) tick();
    for (int i = 0; i < 12; i++) tick();
    chk("dbl_pops", obs_pops, 2);
    chk("dbl_dones", obs_dones, 1);

    // randomized tiles with a random consumer
    for (int t = 0; t < 30; t++) begin
      fill_rand();
      for (int g = $urandom_range(0, 3); g > 0; g--) tick();
      run_tile($urandom_range(0, 12), 1, 0);
    end
    for (int i = 0; i < 5; i++) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
